instruction_fetch: RTL

- Front-end stage directly upstream of instruction decode.
- Generates sequential PCs and issues word requests to the instruction memory.
- Buffers in-order responses in a small FIFO and presents instruction + PC to decode over a valid/ready handshake.
- Handles control-flow redirects by flushing buffered instructions and discarding responses still in flight.

---
 rtl/instruction_fetch.sv | 109 ++++++++++
 1 files changed

// File: rtl/instruction_fetch.sv
// Instruction fetch front end: sequential PC generation, credit-limited imem
// requests, in-order response buffering and redirect flush toward decode.
module instruction_fetch #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rstf,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic [31:0] i_instr,
    output logic        i_instr_valid,
    input  logic        i_instr_ready,
    output logic [31:0] oPC
);
    localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
    // In-flight counters get one spare bit: requests to a new target may be
    // issued while drops of the old stream are still pending.
    localparam int unsigned OW = CW + 1;
    localparam int unsigned SW = OW + 1;

    logic [31:0]   r_pc;
    logic [31:0]   r_rsp_pc;
    logic [OW-1:0] r_outstanding;
    logic [OW-1:0] r_drop_cnt;
    logic [CW-1:0] r_count;
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [31:0]   r_buf_instr [FIFO_DEPTH];
    logic [31:0]   r_buf_pc    [FIFO_DEPTH];

    logic [SW-1:0] w_credit_used;
    logic [31:0]   w_redirect_tgt;
    logic          w_req_fire;
    logic          w_rsp_take;
    logic          w_drop;
    logic          w_push;
    logic          w_pop;

    always_comb begin
        w_credit_used  = SW'(r_count) + SW'(r_outstanding) - SW'(r_drop_cnt);
        w_redirect_tgt = {redirect_pc[31:2], 2'b00};
        // The saturation term never binds while the memory keeps responding.
        imem_req_valid = rstf & ~redirect_valid
                       & (w_credit_used < SW'(FIFO_DEPTH))
                       & (r_outstanding != '1);
        imem_addr      = r_pc;
        w_req_fire     = imem_req_valid & imem_req_ready;
        w_rsp_take     = imem_rsp_valid & (r_outstanding != '0);
        w_drop         = w_rsp_take & (r_drop_cnt != '0);
        w_push         = w_rsp_take & ~w_drop & ~redirect_valid;
        i_instr_valid  = (r_count != '0) & ~redirect_valid;
        i_instr        = r_buf_instr[r_rptr];
        oPC            = r_buf_pc[r_rptr];
        w_pop          = i_instr_valid & i_instr_ready;
    end

    always_ff @(posedge clk) begin
        if (!rstf) begin
            r_pc          <= RESET_PC;
            r_rsp_pc      <= RESET_PC;
            r_outstanding <= '0;
            r_drop_cnt    <= '0;
            r_count       <= '0;
            r_wptr        <= '0;
            r_rptr        <= '0;
        end else if (redirect_valid) begin
            r_pc          <= w_redirect_tgt;
            r_rsp_pc      <= w_redirect_tgt;
            r_outstanding <= r_outstanding - OW'(w_rsp_take);
            r_drop_cnt    <= r_outstanding - OW'(w_rsp_take);
            r_count       <= '0;
            r_wptr        <= '0;
            r_rptr        <= '0;
        end else begin
            if (w_req_fire) begin
                r_pc <= r_pc + 32'd4;
            end
            r_outstanding <= r_outstanding + OW'(w_req_fire) - OW'(w_rsp_take);
            if (w_drop) begin
                r_drop_cnt <= r_drop_cnt - OW'(1);
            end
            if (w_push) begin
                r_rsp_pc <= r_rsp_pc + 32'd4;
                r_wptr   <= r_wptr + AW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + AW'(1);
            end
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
        end
        if (rstf) begin
            assert (!(w_push && !w_pop && (r_count == CW'(FIFO_DEPTH))));
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_buf_instr[r_wptr] <= imem_rsp_data;
            r_buf_pc[r_wptr]    <= r_rsp_pc;
        end
    end
endmodule
